// File: rtl/tt_loader_pkg.sv
// Shared types and helpers for the Tiny Tapeout UART boot loader.
package tt_loader_pkg;

    typedef enum logic [1:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } loaderState_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS,
        STOP
    } rxState_t;

    localparam int LEN_W = 16;

    // Number of byte lanes in one memory word.
    function automatic int bytes_per_word(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/tt_uart_rx.sv
// 8N1 UART receiver with a two-stage synchroniser, start-bit glitch
// rejection and a one-cycle pulse for each good or badly framed byte.
module tt_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byteValid,
    output logic       o_frameErrPulse
);
    import tt_loader_pkg::*;

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [1:0]       r_rxSync;
    logic             r_rxPrev;
    logic             w_rx;
    rxState_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;

    assign w_rx = r_rxSync[1];

    // The pin is asynchronous, so it is brought into the clock domain through
    // two flops that idle high like the line; one more flop gives the
    // previous synced value so a genuine falling edge can be spotted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rxSync <= 2'b11;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxSync <= {r_rxSync[0], i_rx};
            r_rxPrev <= r_rxSync[1];
        end
    end

    // Bit timing: wait half a bit to re-check the start bit in its middle,
    // then sample each data bit and the stop bit a full bit period apart.
    // A low stop bit throws the byte away and reports a framing error instead.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_bitIdx        <= '0;
            r_shift         <= '0;
            o_byte          <= '0;
            o_byteValid     <= 1'b0;
            o_frameErrPulse <= 1'b0;
        end else begin
            o_byteValid     <= 1'b0;
            o_frameErrPulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_rxPrev && !w_rx) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt    <= '0;
                        r_bitIdx <= '0;
                        r_state  <= w_rx ? IDLE : BITS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BITS: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rx) begin
                            o_byte      <= r_shift;
                            o_byteValid <= 1'b1;
                        end else begin
                            o_frameErrPulse <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tt_uart_loader.sv
// Boot loader: takes a 16-bit word count followed by little-endian words
// from the UART and writes them into instruction memory, keeping the core
// in reset until the image is complete or loading is skipped.
module tt_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx,
    input  logic              i_skip,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic              o_ovf
);
    import tt_loader_pkg::*;

    localparam int          BPW   = bytes_per_word(DATA_W);
    localparam int          IDX_W = 3;
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    logic [7:0]       w_byte;
    logic             w_byteValid;
    logic             w_frameErrPulse;
    logic [LEN_W-1:0] w_fullLen;
    logic [LEN_W-1:0] w_nextCnt;
    logic [DATA_W-1:0] w_mergedWord;

    loaderState_t      r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wordCnt;
    logic [IDX_W-1:0]  r_byteIdx;
    logic [DATA_W-1:0] r_word;

    tt_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx           (i_rx),
        .o_byte         (w_byte),
        .o_byteValid    (w_byteValid),
        .o_frameErrPulse(w_frameErrPulse)
    );

    assign w_fullLen = {w_byte, r_len[7:0]};
    assign w_nextCnt = r_wordCnt + 1'b1;

    // Drop the incoming byte into its little-endian lane of the word being built.
    always_comb begin
        w_mergedWord = r_word;
        for (int i = 0; i < BPW; i++) begin
            if (r_byteIdx == IDX_W'(i)) begin
                w_mergedWord[i*8 +: 8] = w_byte;
            end
        end
    end

    // Loader sequencing: two length bytes, then whole words written one per
    // completed word. Words beyond the memory depth are counted but not
    // written so the length still terminates the load. DONE is terminal, and
    // the core reset and busy flag follow the state one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= LEN_LO;
            r_len       <= '0;
            r_wordCnt   <= '0;
            r_byteIdx   <= '0;
            r_word      <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_cpu_rst_n <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            o_wr_en     <= 1'b0;
            o_busy      <= (r_state == LEN_HI) || (r_state == DATA);
            o_cpu_rst_n <= (r_state == DONE);
            if (w_frameErrPulse) begin
                o_frame_err <= 1'b1;
            end
            case (r_state)
                LEN_LO: begin
                    if (i_skip) begin
                        r_state <= DONE;
                    end else if (w_byteValid) begin
                        r_len[7:0] <= w_byte;
                        r_state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_byteValid) begin
                        r_len[15:8] <= w_byte;
                        if (32'(w_fullLen) > DEPTH) begin
                            o_ovf <= 1'b1;
                        end
                        if (w_fullLen == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= DATA;
                            r_wordCnt <= '0;
                            r_byteIdx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_byteValid) begin
                        r_word <= w_mergedWord;
                        if (r_byteIdx == IDX_W'(BPW - 1)) begin
                            if (32'(r_wordCnt) < DEPTH) begin
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= r_wordCnt[ADDR_W-1:0];
                                o_wr_data <= w_mergedWord;
                            end
                            r_wordCnt <= w_nextCnt;
                            r_byteIdx <= '0;
                            if (w_nextCnt == r_len) begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_byteIdx <= r_byteIdx + 1'b1;
                        end
                    end
                end
                DONE: r_state <= DONE;
                default: r_state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_uart_loader.sv
// Self-checking bench for tt_uart_loader: a full-size instance and a
// four-word instance share all inputs; writes are captured and compared
// against a byte-stream model of the load protocol.
module tb_tt_uart_loader;

    localparam int CPB    = 8;
    localparam int DW     = 32;
    localparam int AW     = 10;
    localparam int AW_S   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          skip = 1'b0;

    logic          wrEn, cpuRstN, busy, frameErr, ovf;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          sWrEn, sCpuRstN, sBusy, sFrameErr, sOvf;
    logic [AW_S-1:0] sWrAddr;
    logic [DW-1:0] sWrData;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int lastWrCycle = -1;
    int riseCycle = -1;
    int busyFallCycle = -1;
    logic prevCpu = 1'b0;
    logic prevBusy = 1'b0;

    logic [7:0]    txBytes[$];
    int            gotAddr[$];
    logic [DW-1:0] gotData[$];
    int            sGotAddr[$];
    logic [DW-1:0] sGotData[$];
    int            expAddr[$];
    logic [DW-1:0] expData[$];
    bit            expOvf;
    bit            expDone;

    tt_uart_loader #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_skip(skip),
        .o_wr_en(wrEn), .o_wr_addr(wrAddr), .o_wr_data(wrData),
        .o_cpu_rst_n(cpuRstN), .o_busy(busy), .o_frame_err(frameErr), .o_ovf(ovf)
    );

    tt_uart_loader #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ADDR_W(AW_S)) dutSmall (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_skip(skip),
        .o_wr_en(sWrEn), .o_wr_addr(sWrAddr), .o_wr_data(sWrData),
        .o_cpu_rst_n(sCpuRstN), .o_busy(sBusy), .o_frame_err(sFrameErr), .o_ovf(sOvf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle count used to time-stamp observed events.
    always @(posedge clk) cycle <= cycle + 1;

    // Capture memory writes and the edges of cpu_rst_n and busy away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wrEn) begin
                gotAddr.push_back(int'(wrAddr));
                gotData.push_back(wrData);
                lastWrCycle = cycle;
            end
            if (sWrEn) begin
                sGotAddr.push_back(int'(sWrAddr));
                sGotData.push_back(sWrData);
            end
            if (!prevCpu && cpuRstN) riseCycle = cycle;
            if (prevBusy && !busy) busyFallCycle = cycle;
        end
        prevCpu = cpuRstN;
        prevBusy = busy;
    end

    // Reference: length from the first two good bytes, then whole words
    // little-endian; only words below the memory depth are written.
    task automatic modelLoad(input int depth);
        int len, avail, nWords;
        expAddr.delete();
        expData.delete();
        expOvf = 0;
        expDone = 0;
        if (txBytes.size() >= 2) begin
            len = int'(txBytes[0]) + 256 * int'(txBytes[1]);
            expOvf = (len > depth);
            avail = (txBytes.size() - 2) / 4;
            nWords = (len < avail) ? len : avail;
            expDone = (avail >= len);
            for (int w = 0; w < nWords; w++) begin
                if (w < depth) begin
                    expAddr.push_back(w);
                    expData.push_back({txBytes[2+4*w+3], txBytes[2+4*w+2],
                                       txBytes[2+4*w+1], txBytes[2+4*w]});
                end
            end
        end
    endtask

    task automatic applyByte(input logic [7:0] b, input bit goodStop, input int gap);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = goodStop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        if (goodStop) txBytes.push_back(b);
    endtask

    task automatic applyWord(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) applyByte(w[k*8 +: 8], 1'b1, gap);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        txBytes.delete();
        gotAddr.delete();
        gotData.delete();
        sGotAddr.delete();
        sGotData.delete();
        lastWrCycle = -1;
        riseCycle = -1;
        busyFallCycle = -1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wrEn, wrAddr, wrData, cpuRstN, busy, frameErr, ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %0b/%0h/%0h/%0b/%0b/%0b/%0b want all zero",
                     wrEn, wrAddr, wrData, cpuRstN, busy, frameErr, ovf);
        end
        doReset();
        repeat (5) @(negedge clk);
        checks++;
        if (cpuRstN !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle cpu_rst_n=%0b busy=%0b want 0/0", cpuRstN, busy);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] hdr [10];
        hdr = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyByte(hdr[i], 1'b1, $urandom_range(0, 3));
            if (i == 3) begin
                checks++;
                if (busy !== 1'b1 || cpuRstN !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL basic_busy busy=%0b cpu=%0b want 1/0", busy, cpuRstN);
                end
            end
        end
        repeat (4) @(negedge clk);
        #1;
        modelLoad(1 << AW);
        checks++;
        if (gotAddr.size() != expAddr.size()) begin
            errors++;
            $display("[TB] FAIL basic_count got %0d want %0d", gotAddr.size(), expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
            checks++;
            if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL basic_write%0d got %0d:%h want %0d:%h",
                         i, gotAddr[i], gotData[i], expAddr[i], expData[i]);
            end
        end
        checks++;
        if (gotData.size() < 2 || gotData[0] !== 32'hDEADBEEF || gotData[1] !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL basic_literal got %0d words want DEADBEEF,12345678", gotData.size());
        end
        checks++;
        if (cpuRstN !== 1'b1 || riseCycle != lastWrCycle + 1) begin
            errors++;
            $display("[TB] FAIL basic_cpu_rise cpu=%0b rise=%0d want 1 at %0d",
                     cpuRstN, riseCycle, lastWrCycle + 1);
        end
        checks++;
        if (busy !== 1'b0 || busyFallCycle != lastWrCycle + 1) begin
            errors++;
            $display("[TB] FAIL basic_busy_fall busy=%0b fall=%0d want 0 at %0d",
                     busy, busyFallCycle, lastWrCycle + 1);
        end
    endtask

    task automatic test_zero_len();
        bit seen;
        doReset();
        applyByte(8'h00, 1'b1, 0);
        applyByte(8'h00, 1'b1, 0);
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clk);
            seen = (cpuRstN === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL zero_len_done cpu_rst_n=%0b want 1 within 2 cycles", cpuRstN);
        end
        checks++;
        if (gotAddr.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_len_writes got %0d want 0", gotAddr.size());
        end
    endtask

    task automatic test_skip();
        skip = 1'b1;
        doReset();
        @(negedge clk);
        checks++;
        if (cpuRstN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_cycle1 cpu_rst_n=%0b want 0", cpuRstN);
        end
        @(negedge clk);
        checks++;
        if (cpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skip_cycle2 cpu_rst_n=%0b want 1", cpuRstN);
        end
        skip = 1'b0;
        applyByte(8'h01, 1'b1, 2);
        applyByte(8'h00, 1'b1, 2);
        applyWord($urandom, 1);
        repeat (4) @(negedge clk);
        checks++;
        if (gotAddr.size() != 0 || cpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skip_ignore writes=%0d cpu=%0b want 0/1", gotAddr.size(), cpuRstN);
        end
    endtask

    task automatic test_glitch_frame_err();
        doReset();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        applyByte(8'h02, 1'b1, 1);
        applyByte(8'h00, 1'b1, 1);
        applyWord($urandom, $urandom_range(0, 2));
        checks++;
        if (frameErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ferr_before got %0b want 0", frameErr);
        end
        applyByte(8'($urandom), 1'b0, 2);
        repeat (2) @(negedge clk);
        checks++;
        if (frameErr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ferr_set got %0b want 1", frameErr);
        end
        applyWord($urandom, $urandom_range(0, 2));
        repeat (4) @(negedge clk);
        #1;
        modelLoad(1 << AW);
        checks++;
        if (gotAddr.size() != expAddr.size() || cpuRstN !== expDone) begin
            errors++;
            $display("[TB] FAIL ferr_count got %0d cpu=%0b want %0d cpu=%0b",
                     gotAddr.size(), cpuRstN, expAddr.size(), expDone);
        end
        for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
            checks++;
            if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL ferr_write%0d got %0d:%h want %0d:%h",
                         i, gotAddr[i], gotData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_overflow();
        doReset();
        applyByte(8'h05, 1'b1, 0);
        applyByte(8'h00, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sOvf !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_flag small=%0b big=%0b want 1/0", sOvf, ovf);
        end
        for (int w = 0; w < 5; w++) applyWord($urandom, 0);
        repeat (4) @(negedge clk);
        #1;
        modelLoad(1 << AW_S);
        checks++;
        if (sGotAddr.size() != expAddr.size() || sGotAddr.size() != 4 || sCpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_count got %0d cpu=%0b want %0d cpu=1",
                     sGotAddr.size(), sCpuRstN, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && i < sGotAddr.size(); i++) begin
            checks++;
            if (sGotAddr[i] != expAddr[i] || sGotData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL ovf_write%0d got %0d:%h want %0d:%h",
                         i, sGotAddr[i], sGotData[i], expAddr[i], expData[i]);
            end
        end
        modelLoad(1 << AW);
        checks++;
        if (gotAddr.size() != expAddr.size() || cpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_big_count got %0d cpu=%0b want %0d cpu=1",
                     gotAddr.size(), cpuRstN, expAddr.size());
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        applyByte(8'h04, 1'b1, 0);
        applyByte(8'h00, 1'b1, 0);
        for (int w = 0; w < 4; w++) applyWord($urandom, 0);
        repeat (4) @(negedge clk);
        #1;
        modelLoad(1 << AW_S);
        checks++;
        if (sOvf !== expOvf || sGotAddr.size() != expAddr.size() || sCpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_small ovf=%0b n=%0d cpu=%0b want ovf=%0b n=%0d cpu=1",
                     sOvf, sGotAddr.size(), sCpuRstN, expOvf, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && i < sGotAddr.size(); i++) begin
            checks++;
            if (sGotAddr[i] != expAddr[i] || sGotData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d got %0d:%h want %0d:%h",
                         i, sGotAddr[i], sGotData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_random_loads();
        int len;
        for (int it = 0; it < 3; it++) begin
            doReset();
            len = $urandom_range(1, 3);
            applyByte(8'(len), 1'b1, $urandom_range(0, 3));
            applyByte(8'h00, 1'b1, $urandom_range(0, 3));
            for (int w = 0; w < len; w++) applyWord($urandom, $urandom_range(0, 3));
            repeat (4) @(negedge clk);
            #1;
            modelLoad(1 << AW);
            checks++;
            if (gotAddr.size() != expAddr.size() || cpuRstN !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand%0d_count got %0d cpu=%0b busy=%0b want %0d cpu=1 busy=0",
                         it, gotAddr.size(), cpuRstN, busy, expAddr.size());
            end
            for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
                checks++;
                if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_write%0d got %0d:%h want %0d:%h",
                             it, i, gotAddr[i], gotData[i], expAddr[i], expData[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        doReset();
        applyByte(8'h03, 1'b1, 0);
        applyByte(8'h00, 1'b1, 0);
        applyWord($urandom | 32'h1, 0);
        applyWord($urandom | 32'h1, 0);
        applyByte(8'($urandom), 1'b1, 0);
        applyByte(8'($urandom), 1'b1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({wrEn, wrAddr, wrData, cpuRstN, busy, frameErr, ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got %0b/%0h/%0h/%0b/%0b/%0b/%0b want all zero",
                     wrEn, wrAddr, wrData, cpuRstN, busy, frameErr, ovf);
        end
        doReset();
        applyByte(8'h01, 1'b1, 1);
        applyByte(8'h00, 1'b1, 1);
        applyWord($urandom, 1);
        repeat (4) @(negedge clk);
        #1;
        modelLoad(1 << AW);
        checks++;
        if (gotAddr.size() != 1 || expAddr.size() != 1 || cpuRstN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_count got %0d cpu=%0b want 1 cpu=1", gotAddr.size(), cpuRstN);
        end else begin
            checks++;
            if (gotAddr[0] != 0 || gotData[0] !== expData[0]) begin
                errors++;
                $display("[TB] FAIL midreset_write got %0d:%h want 0:%h", gotAddr[0], gotData[0], expData[0]);
            end
        end
    endtask

    // Scenario sequence followed by the one summary line.
    initial begin
        test_reset();
        test_basic_load();
        test_zero_len();
        test_skip();
        test_glitch_frame_err();
        test_overflow();
        test_back_to_back();
        test_random_loads();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout reached at cycle %0d", cycle);
        $fatal(1, "[TB] timeout");
    end

endmodule
